// File: rtl/clkgate_pkg.sv
// Shared types and defaults for the clock-gated register-file request controller.
package clkgate_pkg;

    localparam int unsigned DefAw      = 4;
    localparam int unsigned DefDw      = 8;
    localparam int unsigned DefHoldCyc = 2;
    localparam int unsigned HoldCntW   = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StDrain = 3'd3,
        StHold  = 3'd4
    } state_e;

endpackage

// File: rtl/clkgate_burst_cnt.sv
// Burst address/beat counter: loads start address and beats-minus-one, steps per beat,
// wraps the address modulo 2^AW and flags the final beat.
module clkgate_burst_cnt
    import clkgate_pkg::*;
#(
    parameter int unsigned AW = DefAw
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] len_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] left_q, left_d;

    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load_i) begin
            addr_d = addr_i;
            left_d = len_i;
        end else if (step_i) begin
            // Natural overflow gives the 0xF -> 0x0 wrap.
            addr_d = addr_q + AW'(1);
            left_d = left_q - AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (left_q == '0);

endmodule

// File: rtl/clkgate_req_ctrl.sv
// Burst request controller driving a clock-gated register file with registered enables.
// Define CLKGATE_REQ_CTRL_HOLD_EN to keep the clock running HOLD_CYC cycles after a burst.
module clkgate_req_ctrl
    import clkgate_pkg::*;
#(
    parameter int unsigned AW       = DefAw,
    parameter int unsigned DW       = DefDw,
    parameter int unsigned HOLD_CYC = DefHoldCyc
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    output logic [DW-1:0] rdata,
    output logic          mem_clken,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);

    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold_cyc
        $error("HOLD_CYC must lie in 1..15");
    end

`ifdef CLKGATE_REQ_CTRL_HOLD_EN
    localparam state_e BurstEnd = StHold;
    localparam logic [HoldCntW-1:0] HoldLoad = HoldCntW'(HOLD_CYC);
    logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;
`else
    localparam state_e BurstEnd = StIdle;
`endif

    state_e        state_q, state_d;
    logic          accept, write_beat, read_beat, beat;
    logic [AW-1:0] cnt_addr;
    logic          cnt_last;

    logic          mem_clken_q, mem_clken_d;
    logic          mem_wr_en_q, mem_wr_en_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_rd_q, mem_rd_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    assign req_ready   = !rst && (state_q == StIdle || state_q == StHold);
    assign wdata_ready = !rst && (state_q == StWrite);
    assign busy        = !rst && (state_q != StIdle);
    assign accept      = req_valid && req_ready;
    assign write_beat  = (state_q == StWrite) && wdata_valid;
    assign read_beat   = (state_q == StRead);
    assign beat        = write_beat || read_beat;

    clkgate_burst_cnt #(
        .AW (AW)
    ) u_burst_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (accept),
        .addr_i (req_addr),
        .len_i  (req_len),
        .step_i (beat),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
`ifdef CLKGATE_REQ_CTRL_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif
        unique case (state_q)
            StIdle:  if (accept) state_d = req_wr ? StWrite : StRead;
            StWrite: if (write_beat && cnt_last) state_d = BurstEnd;
            StRead:  if (cnt_last) state_d = StDrain;
            StDrain: state_d = BurstEnd;
`ifdef CLKGATE_REQ_CTRL_HOLD_EN
            StHold: begin
                hold_cnt_d = hold_cnt_q - HoldCntW'(1);
                if (accept) begin
                    state_d = req_wr ? StWrite : StRead;
                end else if (hold_cnt_q == HoldCntW'(1)) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
`ifdef CLKGATE_REQ_CTRL_HOLD_EN
        if (state_d == StHold && state_q != StHold) hold_cnt_d = HoldLoad;
`endif
    end

    always_comb begin
        // Keep the clock alive through hold-off and across a restart accepted in HOLD.
        mem_clken_d   = beat || (state_d == StHold) || (state_q == StHold && accept);
        mem_wr_en_d   = write_beat;
        mem_addr_d    = beat ? cnt_addr : mem_addr_q;
        mem_data_d    = write_beat ? wdata : mem_data_q;
        mem_rd_d      = read_beat;
        rdata_valid_d = mem_rd_q;
        rdata_d       = mem_rd_q ? mem_q : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mem_clken_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_rd_q      <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_clken_q   <= mem_clken_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_rd_q      <= mem_rd_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
        end
    end

`ifdef CLKGATE_REQ_CTRL_HOLD_EN
    always_ff @(posedge clk) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`endif

    assign mem_clken   = mem_clken_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;

endmodule
